multi_src_stream_ctrl: RTL and testbench
========================================

# multi_src_stream_ctrl

Parametrised stream controller between NUM_SRC producer engines (Fibonacci, timer, future generators) on the producer clock domain and the CDC FIFO write port. It selects one producer on a start pulse, gates its enable, forwards its valid words into the FIFO with full-flag backpressure, and drains the FIFO on stop. It also provides word parity, a sticky drain-timeout error and status LEDs.

## Interface
Parameters:
- NUM_SRC, 2: number of producer channels, 2..8.
- DATA_W, 16: producer/FIFO word width, 1..32.
- DRAIN_TIMEOUT, 255: maximum DRAIN cycles before forced exit, ≥1.

Ports:
- clk  in  1  clock; all logic posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  NUM_SRC  per-source start request, one-cycle pulse (already edge-detected upstream).
- stop  in  1  stop request, one-cycle pulse.
- src_valid  in  NUM_SRC  producer word-valid strobes.
- src_data  in  NUM_SRC*DATA_W  producer words, source i at bits [i*DATA_W +: DATA_W].
- src_en  out  NUM_SRC  producer enables, at most one bit high.
- fifo_full  in  1  FIFO full flag (write-side synchronised).
- fifo_empty  in  1  FIFO empty flag.
- rd_valid  in  1  downstream read-side word valid, synchronised to clk.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_W  FIFO write word.
- active_src  out  max(1,$clog2(NUM_SRC))  index of the selected source.
- busy  out  1  high in every state except IDLE.
- parity  out  1  even parity (XOR reduction) of the last written word.
- word_cnt  out  16  number of words written since last start.
- led  out  6  [3:0] one-hot state (IDLE, RUN, WAIT, DRAIN), [4] drain_err, [5] fifo_full.

## Operation
- States: IDLE, RUN, WAIT, DRAIN.
- IDLE: if any start bit is set, latch the lowest set index into active_src, clear word_cnt and drain_err, and go to RUN. Otherwise stay. A stop pulse in IDLE is ignored. A start and stop in the same cycle: start wins.
- RUN: src_en[active_src]=1. A stop pulse moves to DRAIN. Otherwise fifo_full=1 moves to WAIT. Stop and full in the same cycle go to DRAIN.
- WAIT: all src_en=0. A stop pulse moves to DRAIN. Otherwise fifo_full=0 moves back to RUN.
- DRAIN: all src_en=0, no writes. Go to IDLE when fifo_empty=1 and rd_valid=0. If the drain counter reaches DRAIN_TIMEOUT first, go to IDLE and set drain_err, which stays set until the next accepted start.
- Start pulses outside IDLE are ignored.
- Write path (combinational): fifo_wr_en = (state==RUN) & src_valid[active_src] & ~fifo_full; fifo_wr_data = src_data slice of active_src.
  - Valid strobes from non-selected sources, or strobes outside RUN, are dropped.
- parity updates on every write to ^fifo_wr_data and holds otherwise.
- word_cnt increments on each write and saturates at 16'hFFFF.
- Drain counter: cleared on DRAIN entry, increments each DRAIN cycle, width $clog2(DRAIN_TIMEOUT+1).

## Timing
- Reset values: state IDLE, src_en 0, active_src 0, fifo_wr_en 0, fifo_wr_data is src_data slice 0 (combinational), busy 0, parity 0, word_cnt 0, drain_err 0, led 6'b00_0001 with led[5] following fifo_full.
- Start pulse at cycle N: RUN and src_en high from cycle N+1.
- Write latency: 0 cycles. fifo_wr_en is asserted in the same cycle as src_valid.
- parity and word_cnt reflect a write in cycle N from cycle N+1.
- fifo_full rising in RUN at cycle N: no write in N, state WAIT and src_en low at N+1. fifo_full falling in WAIT at cycle M: RUN at M+1.
- Stop at cycle N: src_en low from N+1. A write in cycle N itself still occurs if its conditions hold.
- DRAIN exit is evaluated each cycle. With fifo_empty=1 and rd_valid=0 on DRAIN entry, IDLE follows 1 cycle later.
- Reset asserted mid-operation: immediate return to reset values. Any word in flight is lost and the FIFO is not flushed by this block.

## Configuration
- STREAM_CTRL_WORD_CNT_EN defined: the word_cnt counter is implemented as described.
- Not defined: no counter is synthesised and word_cnt is tied to 16'h0000. All other behaviour is unchanged.

## Test plan
- NUM_SRC=2, DATA_W=16: start=2'b10, then 5 src_valid[1] words 0x0001..0x0005 -> five fifo_wr_en pulses with matching data, active_src=1, word_cnt=5, parity=0 (^0x0005=0).
- start=2'b11 in one cycle -> active_src=0, src_en=2'b01. src_valid[1] pulses during RUN -> no writes.
- RUN, hold fifo_full=1 for 4 cycles with src_valid[0]=1 -> WAIT after 1 cycle, src_en=0, no writes. Release -> RUN next cycle, writes resume.
- Stop and fifo_full asserted in the same cycle -> DRAIN. Hold fifo_empty=0 for 10 cycles, then fifo_empty=1 and rd_valid=0 -> IDLE, busy=0, drain_err=0.
- DRAIN_TIMEOUT=8, fifo_empty stuck at 0 -> IDLE after 8 DRAIN cycles, led[4]=1. A following start clears led[4].
- Assert rst during RUN with word_cnt=3 -> all outputs return to reset values asynchronously. With STREAM_CTRL_WORD_CNT_EN undefined, word_cnt stays 0 throughout.

Source files
------------

// File: rtl/multi_src_stream_ctrl.sv
// Stream controller: selects one of NUM_SRC producers, forwards its words into a FIFO
// with full backpressure, drains on stop. Optional word counter: STREAM_CTRL_WORD_CNT_EN.
module multi_src_stream_ctrl #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  localparam int unsigned SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        start,
  input  logic                      stop,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_en,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      rd_valid,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [SRC_W-1:0]          active_src,
  output logic                      busy,
  output logic                      parity,
  output logic [15:0]               word_cnt,
  output logic [5:0]                led
);

  localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDrain} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   active_src_q, active_src_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               drain_err_q, drain_err_d;
  logic               parity_q;

  logic               start_any;
  logic [SRC_W-1:0]   start_idx;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;

  // Lowest set start bit wins, so scan from the top down.
  always_comb begin
    start_any = |start;
    start_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (start[i]) start_idx = SRC_W'(i);
    end
  end

  always_comb begin
    sel_valid = src_valid[0];
    sel_data  = src_data[DATA_W-1:0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (active_src_q == SRC_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    drain_cnt_d  = drain_cnt_q;
    drain_err_d  = drain_err_q;
    unique case (state_q)
      StIdle: begin
        if (start_any) begin
          state_d      = StRun;
          active_src_d = start_idx;
          drain_err_d  = 1'b0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else if (fifo_full) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else if (!fifo_full) begin
          state_d = StRun;
        end
      end
      StDrain: begin
        // A clean drain takes priority over a timeout landing in the same cycle.
        if (fifo_empty && !rd_valid) begin
          state_d = StIdle;
        end else if (drain_cnt_q == DrainLast) begin
          state_d     = StIdle;
          drain_err_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      active_src_q <= '0;
      drain_cnt_q  <= '0;
      drain_err_q  <= 1'b0;
      parity_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      drain_cnt_q  <= drain_cnt_d;
      drain_err_q  <= drain_err_d;
      if (fifo_wr_en) parity_q <= ^fifo_wr_data;
    end
  end

`ifdef STREAM_CTRL_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= 16'h0000;
    end else if (state_q == StIdle && start_any) begin
      word_cnt_q <= 16'h0000;
    end else if (fifo_wr_en && word_cnt_q != 16'hFFFF) begin
      word_cnt_q <= word_cnt_q + 16'h0001;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = 16'h0000;
`endif

  always_comb begin
    src_en = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_en[i] = (state_q == StRun) && (active_src_q == SRC_W'(i));
    end
  end

  assign fifo_wr_en   = (state_q == StRun) & sel_valid & ~fifo_full;
  assign fifo_wr_data = sel_data;
  assign active_src   = active_src_q;
  assign busy         = (state_q != StIdle);
  assign parity       = parity_q;
  assign led          = {fifo_full, drain_err_q, state_q == StDrain, state_q == StWait,
                         state_q == StRun, state_q == StIdle};

endmodule

// File: tb/tb_multi_src_stream_ctrl.sv
// Directed bench for multi_src_stream_ctrl: default instance plus a DRAIN_TIMEOUT=8 instance
// sharing the same stimulus.
module tb_multi_src_stream_ctrl;

`ifdef STREAM_CTRL_WORD_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk, rst;
  logic [1:0]  start;
  logic        stop;
  logic [1:0]  src_valid;
  logic [31:0] src_data;
  logic        fifo_full, fifo_empty, rd_valid;

  logic [1:0]  src_en, src_en_to;
  logic        fifo_wr_en, fifo_wr_en_to;
  logic [15:0] fifo_wr_data, fifo_wr_data_to;
  logic        active_src, active_src_to;
  logic        busy, busy_to;
  logic        parity, parity_to;
  logic [15:0] word_cnt, word_cnt_to;
  logic [5:0]  led, led_to;

  int checks = 0;
  int errors = 0;

  multi_src_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .src_valid(src_valid),
    .src_data(src_data), .src_en(src_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rd_valid(rd_valid), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .active_src(active_src), .busy(busy), .parity(parity), .word_cnt(word_cnt), .led(led)
  );

  multi_src_stream_ctrl #(.DRAIN_TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .src_valid(src_valid),
    .src_data(src_data), .src_en(src_en_to), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rd_valid(rd_valid), .fifo_wr_en(fifo_wr_en_to), .fifo_wr_data(fifo_wr_data_to),
    .active_src(active_src_to), .busy(busy_to), .parity(parity_to), .word_cnt(word_cnt_to),
    .led(led_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return CntEn ? 16'(n) : 16'h0000;
  endfunction

  initial begin
    rst = 1'b1; start = '0; stop = 1'b0; src_valid = '0;
    src_data = {16'hBEEF, 16'h1234};
    fifo_full = 1'b0; fifo_empty = 1'b1; rd_valid = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_src_en", src_en, 0);
    check("rst_active", active_src, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 16'h1234);
    check("rst_parity", parity, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_led", led, 6'b00_0001);
    rst = 1'b0;
    cyc();

    // Start source 1, stream five words.
    start = 2'b10;
    #1 check("t1_idle_before", busy, 0);
    cyc();
    start = '0;
    #1;
    check("t1_busy", busy, 1);
    check("t1_active", active_src, 1);
    check("t1_src_en", src_en, 2'b10);
    check("t1_led_run", led, 6'b00_0010);
    for (int k = 1; k <= 5; k++) begin
      src_valid = 2'b10;
      src_data  = {16'(k), 16'h00FF};
      #1;
      check("t1_wr_en", fifo_wr_en, 1);
      check("t1_wr_data", fifo_wr_data, 32'(k));
      cyc();
    end
    src_valid = 2'b00;
    #1;
    check("t1_word_cnt", word_cnt, exp_cnt(5));
    check("t1_parity", parity, 0);
    src_valid = 2'b01;
    #1 check("t1_unsel_drop", fifo_wr_en, 0);
    src_valid = 2'b00;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    check("t1_drain", led[3:0], 4'b1000);
    check("t1_drain_src_en", src_en, 0);
    cyc();
    #1 check("t1_idle", led[3:0], 4'b0001);

    // Stop in IDLE is ignored.
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1 check("idle_stop_ign", led[3:0], 4'b0001);

    // Simultaneous starts (plus stop): lowest index wins.
    start = 2'b11;
    stop  = 1'b1;
    cyc();
    start = '0;
    stop  = 1'b0;
    #1;
    check("t2_active", active_src, 0);
    check("t2_src_en", src_en, 2'b01);
    src_valid = 2'b10;
    #1 check("t2_unsel_drop", fifo_wr_en, 0);
    cyc();
    src_valid = 2'b00;
    #1 check("t2_word_cnt_clr", word_cnt, 0);

    // Backpressure: full for 4 cycles, then release.
    src_valid = 2'b01;
    src_data  = {16'h0000, 16'h00A7};
    fifo_full = 1'b1;
    #1 check("t3_full_no_wr", fifo_wr_en, 0);
    cyc();
    #1;
    check("t3_wait_led", led, 6'b10_0100);
    check("t3_wait_src_en", src_en, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check("t3_wait_hold", led[3:0], 4'b0100);
      check("t3_wait_no_wr", fifo_wr_en, 0);
    end
    fifo_full = 1'b0;
    #1 check("t3_release_still_wait", led[3:0], 4'b0100);
    cyc();
    #1;
    check("t3_run_again", led[3:0], 4'b0010);
    check("t3_resume_wr", fifo_wr_en, 1);
    check("t3_resume_data", fifo_wr_data, 16'h00A7);
    cyc();
    src_valid = 2'b00;
    #1;
    check("t3_word_cnt", word_cnt, exp_cnt(1));
    check("t3_parity", parity, 1);

    // Stop and full together -> DRAIN; slow drain then clean exit.
    stop = 1'b1;
    fifo_full = 1'b1;
    fifo_empty = 1'b0;
    cyc();
    stop = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check("t4_drain_hold", led[3:0], 4'b1000);
      cyc();
    end
    fifo_empty = 1'b1;
    rd_valid   = 1'b1;
    #1 check("t4_rd_valid_hold", led[3:0], 4'b1000);
    cyc();
    #1 check("t4_rd_valid_hold2", led[3:0], 4'b1000);
    rd_valid = 1'b0;
    cyc();
    #1;
    check("t4_idle", led[3:0], 4'b0001);
    check("t4_busy", busy, 0);
    check("t4_no_err", led[4], 0);

    // Drain timeout on the DRAIN_TIMEOUT=8 instance.
    rst = 1'b1;
    #1 rst = 1'b0;
    start = 2'b01;
    cyc();
    start = '0;
    fifo_empty = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 check("t5_drain_hold", led_to[3:0], 4'b1000);
      cyc();
    end
    #1;
    check("t5_timeout_idle_err", led_to[4:0], 5'b1_0001);
    check("t5_busy", busy_to, 0);
    fifo_empty = 1'b1;
    start = 2'b01;
    cyc();
    start = '0;
    #1;
    check("t5_err_cleared", led_to[4], 0);
    check("t5_run", led_to[3:0], 4'b0010);

    // Asynchronous reset during RUN after three writes.
    rst = 1'b1;
    #1 rst = 1'b0;
    start = 2'b10;
    cyc();
    start = '0;
    src_valid = 2'b10;
    src_data = {16'h0001, 16'h0000};
    cyc();
    src_data = {16'h0002, 16'h0000};
    cyc();
    src_data = {16'h0004, 16'h0000};
    cyc();
    src_valid = 2'b00;
    #1;
    check("t6_word_cnt", word_cnt, exp_cnt(3));
    check("t6_parity", parity, 1);
    check("t6_active", active_src, 1);
    src_data  = {16'h4444, 16'h1357};
    src_valid = 2'b10;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_src_en", src_en, 0);
    check("t6_rst_active", active_src, 0);
    check("t6_rst_wr_en", fifo_wr_en, 0);
    check("t6_rst_wr_data", fifo_wr_data, 16'h1357);
    check("t6_rst_parity", parity, 0);
    check("t6_rst_word_cnt", word_cnt, 0);
    check("t6_rst_led", led, 6'b00_0001);
    src_valid = 2'b00;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
